// File: rtl/lvds_train_tx_if.sv
// Parallel-side bundle of the LVDS transmit trainer: link/training controls,
// payload input and the word stream towards the serializer.
interface lvds_train_tx_if;
    logic       link_ok;
    logic       train_req;
    logic       test_mode;
    logic [9:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [9:0] tx_data;
    logic       train_active;
    logic       data_err;

    modport slave (
        input  link_ok, train_req, test_mode, data_in, data_valid,
        output data_ready, tx_data, train_active, data_err
    );

    modport master (
        output link_ok, train_req, test_mode, data_in, data_valid,
        input  data_ready, tx_data, train_active, data_err
    );
endinterface

// File: rtl/lvds_train_tx.sv
// LVDS transmit link trainer: alternating comma training, sync period, then
// payload or counting test pattern; falls back to training on link loss.
//
// state   | meaning
// TRAIN   | alternating commas, at least TRAIN_MIN words, waits for link_ok_s
// SYNC    | SYNC_LEN more alternating commas before payload
// DATA    | payload / test pattern / comma filler, data_ready high
module lvds_train_tx #(
    parameter int         TRAIN_MIN = 32,
    parameter int         SYNC_LEN  = 16,
    parameter logic [9:0] COMMA1    = 10'b01_0111_1100,
    parameter logic [9:0] COMMA2    = 10'b10_1000_0011
) (
    input  logic              i_tx_clk,
    input  logic              i_tx_locked,
    lvds_train_tx_if.slave    bus
);

    localparam int TW = (TRAIN_MIN > 2) ? $clog2(TRAIN_MIN) : 1;
    localparam int SW = (SYNC_LEN  > 2) ? $clog2(SYNC_LEN)  : 1;
    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_MIN - 1);
    localparam logic [SW-1:0] SYNC_LAST  = SW'(SYNC_LEN - 1);

    typedef enum logic [1:0] {
        S_TRAIN = 2'd0,
        S_SYNC  = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t        r_state;
    logic [1:0]    r_sync;
    logic [TW-1:0] r_train_cnt;
    logic [SW-1:0] r_sync_cnt;
    logic [9:0]    r_pat;
    logic          r_phase;
    logic [9:0]    r_tx_data;
    logic          r_train_active;
    logic          r_data_ready;
    logic          r_data_err;

    logic          w_link_ok_s;
    logic          w_retrain;
    logic [9:0]    w_comma_next;
    logic [9:0]    w_pat_inc;
    logic [9:0]    w_pat_next;
    logic          w_din_comma;

    assign w_link_ok_s  = r_sync[1];
    assign w_retrain    = !w_link_ok_s || bus.train_req;
    assign w_comma_next = r_phase ? COMMA1 : COMMA2;
    assign w_din_comma  = (bus.data_in == COMMA1) || (bus.data_in == COMMA2);

    // The test pattern must never emit a comma, so those two codes are stepped over.
    assign w_pat_inc  = r_pat + 10'd1;
    assign w_pat_next = ((w_pat_inc == COMMA1) || (w_pat_inc == COMMA2)) ?
                        (w_pat_inc + 10'd1) : w_pat_inc;

    always_ff @(posedge i_tx_clk or negedge i_tx_locked) begin
        if (!i_tx_locked) begin
            r_state        <= S_TRAIN;
            r_sync         <= 2'b00;
            r_train_cnt    <= '0;
            r_sync_cnt     <= '0;
            r_pat          <= 10'd0;
            r_phase        <= 1'b0;
            r_tx_data      <= COMMA1;
            r_train_active <= 1'b1;
            r_data_ready   <= 1'b0;
            r_data_err     <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], bus.link_ok};
            case (r_state)
                S_TRAIN: begin
                    r_tx_data <= w_comma_next;
                    r_phase   <= ~r_phase;
                    if ((r_train_cnt == TRAIN_LAST) && w_link_ok_s && !bus.train_req) begin
                        r_state    <= S_SYNC;
                        r_sync_cnt <= '0;
                    end else if (r_train_cnt != TRAIN_LAST) begin
                        r_train_cnt <= r_train_cnt + 1'b1;
                    end
                end
                S_SYNC: begin
                    r_tx_data <= w_comma_next;
                    r_phase   <= ~r_phase;
                    if (w_retrain) begin
                        r_state     <= S_TRAIN;
                        r_train_cnt <= '0;
                    end else if (r_sync_cnt == SYNC_LAST) begin
                        r_state        <= S_DATA;
                        r_data_ready   <= 1'b1;
                        r_train_active <= 1'b0;
                        r_pat          <= 10'd0;
                    end else begin
                        r_sync_cnt <= r_sync_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_retrain) begin
                        r_state        <= S_TRAIN;
                        r_data_ready   <= 1'b0;
                        r_train_active <= 1'b1;
                        r_tx_data      <= COMMA1;
                        r_phase        <= 1'b1;
                        r_train_cnt    <= '0;
                    end else if (bus.test_mode) begin
                        r_tx_data <= r_pat;
                        r_pat     <= w_pat_next;
                    end else if (bus.data_valid) begin
                        // Commas in payload are forwarded untouched but flagged.
                        r_tx_data <= bus.data_in;
                        if (w_din_comma) begin
                            r_data_err <= 1'b1;
                        end
                    end else begin
                        r_tx_data <= w_comma_next;
                        r_phase   <= ~r_phase;
                    end
                end
                default: begin
                    r_state <= S_TRAIN;
                end
            endcase
        end
    end

    assign bus.tx_data      = r_tx_data;
    assign bus.train_active = r_train_active;
    assign bus.data_ready   = r_data_ready;
    assign bus.data_err     = r_data_err;

endmodule

// File: doc/lvds_train_tx.md
# lvds_train_tx

Transmit-side link trainer and word framer for the 10-bit LVDS link. It drives the serializer's parallel word input. After PLL lock it sends alternating comma words so the far-end word aligner can bitslip and lock. Once the far end reports alignment and a fixed sync period has passed, it carries payload words or an internal counting test pattern. It falls back to training whenever the far end loses alignment or local logic requests a retrain.

## Interface
- TRAIN_MIN, 32: minimum number of comma words sent in TRAIN (≥2).
- SYNC_LEN, 16: comma words sent in SYNC before payload (≥1).
- COMMA1, 10'b01_0111_1100: comma word A.
- COMMA2, 10'b10_1000_0011: comma word B.

Ports:
- tx_clk  in  1  serializer parallel clock; all logic is on its rising edge.
- tx_locked  in  1  asynchronous, active-low reset (TX PLL lock); low clears everything.
- link_ok  in  1  far-end alignment-done flag, asynchronous; double-flop synchronised internally to link_ok_s.
- train_req  in  1  synchronous level; high forces and holds TRAIN.
- test_mode  in  1  synchronous; in DATA, selects the internal counting pattern instead of data_in.
- data_in  in  10  payload word.
- data_valid  in  1  payload qualifier.
- data_ready  out  1  registered; high only in DATA; a word transfers when data_valid && data_ready.
- tx_data  out  10  registered word to the serializer.
- train_active  out  1  registered; high in TRAIN and SYNC.
- data_err  out  1  sticky; set when an accepted payload word equals COMMA1 or COMMA2.

## Operation
- States: TRAIN, SYNC, DATA. Counters: train_cnt (saturating at TRAIN_MIN-1), sync_cnt, pat (10-bit), and a phase bit for comma alternation.
- Reset values:
  - State: TRAIN, all counters 0, phase 0.
  - Outputs: tx_data = COMMA1, train_active = 1, data_ready = 0, data_err = 0.
  - Synchroniser flops: 0.
- **TRAIN**, each edge:
  - tx_data ← COMMA2 if phase = 0, else COMMA1; phase toggles.
  - If train_cnt = TRAIN_MIN-1 && link_ok_s && !train_req: go to SYNC, sync_cnt ← 0.
  - Otherwise train_cnt increments, saturating.
- **SYNC**, each edge:
  - Commas keep alternating.
  - If link_ok_s = 0 or train_req = 1: go to TRAIN, with train_cnt ← 0.
  - Else if sync_cnt = SYNC_LEN-1: go to DATA, data_ready ← 1, train_active ← 0, pat ← 0.
  - Else sync_cnt increments.
- **DATA**, each edge:
  - test_mode = 1: tx_data ← pat. pat then advances by 1, skipping COMMA1 and COMMA2 (0x17B→0x17D, 0x282→0x284), and wrapping 0x3FF→0x000. data_valid is ignored.
  - test_mode = 0 and data_valid = 1: tx_data ← data_in. If data_in is a comma, data_err ← 1 and the word is still transmitted unchanged.
  - test_mode = 0 and data_valid = 0: tx_data ← the next alternating comma (filler). pat holds.
- **Exit from DATA:** if link_ok_s = 0 or train_req = 1, on that same edge:
  - State goes to TRAIN; data_ready ← 0; train_active ← 1.
  - tx_data ← COMMA1, phase ← 1, train_cnt ← 0.
  - The data_in presented on that edge is not accepted.
- **Priority:** train_req and loss of link_ok_s override every other transition. A transition to TRAIN always restarts the full TRAIN_MIN count.
- **data_err** clears only on reset.
- **tx_locked low at any time:** the block returns to reset values immediately (asynchronously). Training restarts from scratch after release.

## Timing
- Edges are counted from the first tx_clk edge after tx_locked rises (edge 1).
- link_ok is visible to the FSM 2 edges after it changes (two-flop synchroniser).
- Best case, with link_ok already high and train_req low:
  - TRAIN occupies edges 1–32 and SYNC occupies edges 33–48.
  - data_ready and train_active change on edge 48.
  - The first payload or pattern word appears on tx_data after edge 49.
- Payload latency: data_in sampled at edge n appears on tx_data after edge n; one register, no bubbles. Throughput is one word per cycle.
- Comma streams strictly alternate, with no two identical consecutive commas, across the TRAIN→SYNC and SYNC→DATA transitions.
- link_ok loss in DATA: data_ready falls 3 edges after link_ok falls (2 synchroniser edges plus 1 register edge).

## Test plan
- **Bring-up:** release tx_locked with link_ok = 1, test_mode = 1.
  - tx_data is COMMA1, COMMA2, … alternating through edge 48.
  - data_ready rises after edge 48.
  - tx_data = 0x000 after edge 49 and 0x001 after edge 50.
- **Late link:** hold link_ok = 0 for 100 edges, then raise it.
  - TRAIN persists with alternating commas.
  - DATA is entered exactly 2+1+SYNC_LEN edges after link_ok rises.
- **Pattern skip/wrap:** run test_mode for 1100 cycles.
  - 0x17C and 0x283 never appear.
  - 0x17B is followed by 0x17D; 0x3FF is followed by 0x000.
- **Payload:** test_mode = 0, data_valid toggling, data_in = 0x155 then 0x2AA.
  - Words appear one edge later; gaps are filled with alternating commas.
  - data_in = 0x17C with data_valid: transmitted as 0x17C and data_err goes high, staying high until reset.
- **Retrain:** pulse train_req for 1 cycle in DATA, and separately drop link_ok in SYNC and in DATA.
  - Next edge (train_req) or 3 edges later (link_ok): TRAIN, tx_data = COMMA1, data_ready = 0.
  - The full TRAIN_MIN+SYNC_LEN sequence repeats before DATA.
- **Reset mid-operation:** drop tx_locked in DATA for less than one cycle, asynchronously.
  - Outputs return to reset values immediately.
  - The bring-up timing repeats exactly after release.
